// File: rtl/reset_clear_pkg.sv
// Shared definitions for the reset/clear control stage: FSM encoding,
// default timing parameters and counter sizing.
package reset_clear_pkg;

  localparam logic [1:0] StateReset = 2'd0;
  localparam logic [1:0] StateHold  = 2'd1;
  localparam logic [1:0] StateRun   = 2'd2;
  localparam logic [1:0] StateClear = 2'd3;

  typedef enum logic [1:0] {
    StReset = StateReset,
    StHold  = StateHold,
    StRun   = StateRun,
    StClear = StateClear
  } state_e;

  localparam int unsigned DefaultHoldCycles  = 16;
  localparam int unsigned DefaultClearCycles = 4;

  // Width of a down-counter that must hold max(a, b) - 1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return ($clog2(m) < 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Reset synchronizer: asserts asynchronously with reset_n, deasserts on the
// SYNC_STAGES-th rising clock edge after reset_n rises.
module reset_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic rst_sync_n
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/reset_clear_ctrl.sv
// Reset/clear control: synchronized reset, post-reset flush window and
// request-driven clear pulses for the downstream flip-flop banks.
module reset_clear_ctrl
  import reset_clear_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned HOLD_CYCLES  = DefaultHoldCycles,
  parameter int unsigned CLEAR_CYCLES = DefaultClearCycles
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_req,
  output logic rst_sync_n,
  output logic clear_n,
  output logic ready,
  output logic clear_done
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, CLEAR_CYCLES);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] ClearLoad = CntW'(CLEAR_CYCLES - 1);

  logic            w_rst_sync_n;
  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_clear_n;
  logic            r_ready;
  logic            r_clear_done;

  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .rst_sync_n(w_rst_sync_n)
  );

  // Everything below shares the synchronized reset so it leaves reset on the same edge.
  always_ff @(posedge clk or negedge w_rst_sync_n) begin
    if (!w_rst_sync_n) begin
      r_state      <= StReset;
      r_cnt        <= '0;
      r_clear_n    <= 1'b0;
      r_ready      <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      r_clear_done <= 1'b0;
      unique case (r_state)
        StReset: begin
          r_state <= StHold;
          r_cnt   <= HoldLoad;
        end
        StHold: begin
          if (r_cnt == '0) begin
            r_state   <= StRun;
            r_clear_n <= 1'b1;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        StRun: begin
          if (clear_req) begin
            r_state   <= StClear;
            r_cnt     <= ClearLoad;
            r_clear_n <= 1'b0;
            r_ready   <= 1'b0;
          end
        end
        StClear: begin
          // A request while clearing restarts the window, even on the final cycle.
          if (clear_req) begin
            r_cnt <= ClearLoad;
          end else if (r_cnt == '0) begin
            r_state      <= StRun;
            r_clear_n    <= 1'b1;
            r_ready      <= 1'b1;
            r_clear_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= StReset;
      endcase
    end
  end

  assign rst_sync_n = w_rst_sync_n;
  assign clear_n    = r_clear_n;
  assign ready      = r_ready;
  assign clear_done = r_clear_done;

endmodule

// File: tb/tb_reset_clear_ctrl.sv
// Scoreboard bench for reset_clear_ctrl: a default instance and a minimal
// (3,1,1) instance, expected output vectors queued per clock and checked at negedge.
module tb_reset_clear_ctrl;

  localparam logic [3:0] VRst  = 4'b0000;  // {rst_sync_n, clear_n, ready, clear_done}
  localparam logic [3:0] VHold = 4'b1000;
  localparam logic [3:0] VClr  = 4'b1000;
  localparam logic [3:0] VRun  = 4'b1110;
  localparam logic [3:0] VDone = 4'b1111;

  logic clk = 1'b0;
  logic reset_n_a = 1'b1;
  logic reset_n_b = 1'b1;
  logic clear_req_a = 1'b0;
  logic clear_req_b = 1'b0;
  logic rst_sync_n_a, clear_n_a, ready_a, clear_done_a;
  logic rst_sync_n_b, clear_n_b, ready_b, clear_done_b;
  logic [7:0] w_obs;
  logic [7:0] mon_exp;
  logic [7:0] exp_q[$];
  string cur_tag = "reset";
  int unsigned n_tests = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  reset_clear_ctrl #(
    .SYNC_STAGES (2),
    .HOLD_CYCLES (16),
    .CLEAR_CYCLES(4)
  ) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n_a),
    .clear_req (clear_req_a),
    .rst_sync_n(rst_sync_n_a),
    .clear_n   (clear_n_a),
    .ready     (ready_a),
    .clear_done(clear_done_a)
  );

  reset_clear_ctrl #(
    .SYNC_STAGES (3),
    .HOLD_CYCLES (1),
    .CLEAR_CYCLES(1)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n_b),
    .clear_req (clear_req_b),
    .rst_sync_n(rst_sync_n_b),
    .clear_n   (clear_n_b),
    .ready     (ready_b),
    .clear_done(clear_done_b)
  );

  assign w_obs = {rst_sync_n_a, clear_n_a, ready_a, clear_done_a,
                  rst_sync_n_b, clear_n_b, ready_b, clear_done_b};

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b want %b", tag, $time, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      check_eq(cur_tag, w_obs, mon_exp);
    end
  end

  // Drive inputs for the next rising edge and queue the outputs expected after it.
  task automatic tick(input logic ra, input logic rb, input logic [3:0] ea,
                      input logic [3:0] eb);
    clear_req_a = ra;
    clear_req_b = rb;
    exp_q.push_back({ea, eb});
    @(negedge clk);
    #1;
  endtask

  // Outputs after edge j following reset release, for S sync stages and H hold cycles.
  function automatic logic [3:0] boot_exp(input int j, input int s, input int h);
    if (j < s) return VRst;
    else if (j <= s + h) return VHold;
    else return VRun;
  endfunction

  initial begin
    #2;
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    @(negedge clk);
    #1;
    repeat (3) tick(1'b0, 1'b0, VRst, VRst);

    // Release A 3 ns after a rising edge.
    cur_tag = "boot_a";
    exp_q.push_back({VRst, VRst});
    @(posedge clk);
    #3 reset_n_a = 1'b1;
    @(negedge clk);
    #1;
    for (int j = 1; j <= 20; j++) tick(1'b0, 1'b0, boot_exp(j, 2, 16), VRst);

    cur_tag = "pulse_a";
    tick(1'b1, 1'b0, VClr, VRst);
    repeat (3) tick(1'b0, 1'b0, VClr, VRst);
    tick(1'b0, 1'b0, VDone, VRst);
    tick(1'b0, 1'b0, VRun, VRst);

    cur_tag = "held_a";
    repeat (10) tick(1'b1, 1'b0, VClr, VRst);
    repeat (3) tick(1'b0, 1'b0, VClr, VRst);
    tick(1'b0, 1'b0, VDone, VRst);
    repeat (2) tick(1'b0, 1'b0, VRun, VRst);

    // Short reset glitch between edges while a clear is in progress.
    cur_tag = "glitch_a";
    tick(1'b1, 1'b0, VClr, VRst);
    tick(1'b0, 1'b0, VClr, VRst);
    reset_n_a = 1'b0;
    #1 check_eq("glitch_async", w_obs, {VRst, VRst});
    #2 reset_n_a = 1'b1;

    // Reboot with requests on the HOLD entry, mid-HOLD and HOLD exit edges.
    cur_tag = "reboot_a";
    for (int j = 1; j <= 21; j++) begin
      tick((j == 3) || (j == 10) || (j == 19), 1'b0, boot_exp(j, 2, 16), VRst);
    end

    cur_tag = "boot_b";
    exp_q.push_back({VRun, VRst});
    @(posedge clk);
    #3 reset_n_b = 1'b1;
    @(negedge clk);
    #1;
    for (int j = 1; j <= 6; j++) tick(1'b0, 1'b0, VRun, boot_exp(j, 3, 1));

    cur_tag = "pulse_b";
    tick(1'b0, 1'b1, VRun, VClr);
    tick(1'b0, 1'b0, VRun, VDone);
    tick(1'b0, 1'b0, VRun, VRun);

    cur_tag = "held_b";
    tick(1'b0, 1'b1, VRun, VClr);
    tick(1'b0, 1'b1, VRun, VClr);
    tick(1'b0, 1'b0, VRun, VDone);
    tick(1'b0, 1'b0, VRun, VRun);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
